// File: rtl/rsa_pkg.sv
// Shared types and defaults for the RSA modular exponentiation engine.
package rsa_pkg;

    localparam int RSA_WIDTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SQUARE,
        ST_MULT,
        ST_DONE
    } rsa_state_t;

endpackage

// File: rtl/rsa_modmul.sv
// Interleaved bit-serial modular multiplier: result = a*b mod m in WIDTH steps.
// The first step happens on the edge that samples start, so back-to-back
// products can be chained with no idle cycle. done is high during the cycle
// whose edge performs the final step, and result is valid alongside it.
module rsa_modmul
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             start,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt;
    logic [CW-1:0]    bit_idx;
    logic [WIDTH+1:0] p_q;
    logic [WIDTH+1:0] p_base;
    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] addend;
    logic [WIDTH+1:0] p_sum;
    logic [WIDTH+1:0] p_red1;
    logic [WIDTH+1:0] p_next;

    // One shift-add step followed by up to two conditional subtractions of m.
    always_comb begin
        m_ext   = {2'b00, m};
        bit_idx = start ? CW'(WIDTH - 1) : cnt;
        p_base  = start ? '0 : p_q;
        addend  = a[bit_idx] ? {2'b00, b} : '0;
        p_sum   = (p_base << 1) + addend;
        p_red1  = (p_sum >= m_ext) ? (p_sum - m_ext) : p_sum;
        p_next  = (p_red1 >= m_ext) ? (p_red1 - m_ext) : p_red1;
        done    = busy && (cnt == '0);
        result  = p_next[WIDTH-1:0];
    end

    // Step counter and partial-product register; cancel drops an operation in flight.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            busy <= 1'b0;
            cnt  <= '0;
            p_q  <= '0;
        end else if (ena) begin
            if (cancel) begin
                busy <= 1'b0;
            end else if (start) begin
                busy <= 1'b1;
                cnt  <= CW'(WIDTH - 2);
                p_q  <= p_next;
            end else if (busy) begin
                p_q <= p_next;
                if (cnt == '0) begin
                    busy <= 1'b0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rsa_modexp_core.sv
// Bit-serial RSA engine: cipher = plain^exponent mod modulus, scanning the
// exponent MSB first with square-and-multiply on top of rsa_modmul.
// Optional macro RSA_CONST_TIME_EN: run MULT for every exponent bit and
// discard the product on zero bits, making latency data-independent.
module rsa_modexp_core
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             en_rsa,
    input  logic             clear_rsa,
    input  logic [WIDTH-1:0] plain,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic             eoc_rsa,
    output logic [WIDTH-1:0] cipher
);

    localparam int IW = $clog2(WIDTH);

    rsa_state_t       state;
    rsa_state_t       state_next;
    logic             run;
    logic             advance;
    logic             mod_small;
    logic [WIDTH-1:0] plain_q;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] mod_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [IW-1:0]    idx;
    logic             mm_start;
    logic             mm_busy;
    logic             mm_done;
    logic [WIDTH-1:0] mm_b;
    logic [WIDTH-1:0] mm_result;

    assign run       = en_rsa & clear_rsa;
    assign mod_small = (mod_q <= WIDTH'(1));

    rsa_modmul #(.WIDTH(WIDTH)) u_modmul (
        .clk    (clk),
        .rstb   (rstb),
        .ena    (ena),
        .start  (mm_start),
        .cancel (!run),
        .a      (acc),
        .b      (mm_b),
        .m      (mod_q),
        .busy   (mm_busy),
        .done   (mm_done),
        .result (mm_result)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state <= ST_IDLE;
        end else if (ena) begin
            state <= state_next;
        end
    end

    // Next state, multiplier control, accumulator update and bit-advance decision.
    always_comb begin
        state_next = state;
        mm_start   = 1'b0;
        mm_b       = acc;
        acc_next   = acc;
        advance    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (!run)          state_next = ST_IDLE;
                else if (mod_small) state_next = ST_DONE;
                else               state_next = ST_SQUARE;
            end
            ST_SQUARE: begin
                if (!run) begin
                    state_next = ST_IDLE;
                end else begin
                    mm_start = !mm_busy;
                    if (mm_done) begin
                        acc_next = mm_result;
`ifdef RSA_CONST_TIME_EN
                        state_next = ST_MULT;
`else
                        if (exp_q[idx]) begin
                            state_next = ST_MULT;
                        end else begin
                            advance    = 1'b1;
                            state_next = (idx == '0) ? ST_DONE : ST_SQUARE;
                        end
`endif
                    end
                end
            end
            ST_MULT: begin
                mm_b = plain_q;
                if (!run) begin
                    state_next = ST_IDLE;
                end else begin
                    mm_start = !mm_busy;
                    if (mm_done) begin
`ifdef RSA_CONST_TIME_EN
                        acc_next = exp_q[idx] ? mm_result : acc;
`else
                        acc_next = mm_result;
`endif
                        advance    = 1'b1;
                        state_next = (idx == '0) ? ST_DONE : ST_SQUARE;
                    end
                end
            end
            ST_DONE: begin
                if (!run) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand capture, accumulator, bit index, result register and end-of-conversion flag.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            plain_q <= '0;
            exp_q   <= '0;
            mod_q   <= '0;
            acc     <= '0;
            idx     <= '0;
            cipher  <= '0;
            eoc_rsa <= 1'b0;
        end else if (ena) begin
            eoc_rsa <= (state_next == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        plain_q <= plain;
                        exp_q   <= exponent;
                        mod_q   <= modulus;
                    end
                end
                ST_LOAD: begin
                    acc <= mod_small ? '0 : WIDTH'(1);
                    idx <= IW'(WIDTH - 1);
                    if (run && mod_small) cipher <= '0;
                end
                ST_SQUARE, ST_MULT: begin
                    if (run && mm_done) acc <= acc_next;
                    if (advance) begin
                        if (idx == '0) cipher <= acc_next;
                        else           idx    <= idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/rsa_modexp_core.md
# rsa_modexp_core

Bit-serial RSA modular exponentiation engine computing cipher = plain^exponent mod modulus. It is the execution end of the RSA enable handshake: it consumes en_rsa and clear_rsa from the peripheral's enable/IRQ controller and returns eoc_rsa when the result is valid. The peripheral register bank supplies the operands and reads back the result.

## Interface
- WIDTH, 8: operand/result width in bits, ≥ 4.
- clk  in  1  clock.
- rstb  in  1  reset, synchronous, active-low, sampled on posedge clk.
- ena  in  1  global clock enable. When low, all state freezes.
- en_rsa  in  1  block enable from the controller.
- clear_rsa  in  1  active-low clear. Low holds the core cleared; high releases it.
- plain  in  WIDTH  message operand. Required: plain < modulus.
- exponent  in  WIDTH  exponent operand.
- modulus  in  WIDTH  modulus operand.
- eoc_rsa  out  1  end of conversion; a level signal.
- cipher  out  WIDTH  result register.

## Operation
- run = en_rsa & clear_rsa. All actions below occur only on edges with ena=1.
- States: IDLE, LOAD, SQUARE, MULT, DONE.
- **IDLE**
  - eoc_rsa=0.
  - If run=1: latch plain, exponent and modulus into internal copies, then go to LOAD.
- **LOAD** (1 cycle)
  - acc = (modulus ≤ 1) ? 0 : 1.
  - Exponent bit index i = WIDTH-1.
  - If modulus ≤ 1, go directly to DONE. Otherwise go to SQUARE.
- **SQUARE**
  - Computes acc = acc·acc mod modulus using the interleaved modmul, which takes WIDTH cycles.
  - Then goes to MULT if exponent[i]=1. Otherwise it advances i.
- **MULT**
  - Computes acc = acc·plain mod modulus, which takes WIDTH cycles.
  - Then advances i.
- **Advance i**
  - If i=0: cipher ← acc, go to DONE.
  - Otherwise: i ← i-1, go to SQUARE.
- **DONE**
  - eoc_rsa=1 and holds while run=1.
  - When run=0, go to IDLE; eoc_rsa drops on that edge.
- **Interleaved modmul** of a·b, one step per cycle, j from WIDTH-1 down to 0:
  - P ← 2P + (a[j] ? b : 0), followed by up to two conditional subtractions of modulus.
  - P is WIDTH+2 bits wide; no overflow is possible because 2P + b < 4·modulus.
  - P is cleared at the start of each modmul.
- **run=0 in any state other than IDLE**
  - The next edge aborts to IDLE and sets eoc_rsa=0.
  - cipher is unchanged.
- Operands are sampled only on the IDLE→LOAD edge. Changes after that edge are ignored.
- cipher is written only on completion. It otherwise holds its last value.
- **Reset values:** state IDLE, eoc_rsa=0, cipher=0, acc=0, P=0.
- If plain ≥ modulus, the result is undefined but the engine must still terminate with the normal latency.

## Timing
- Edge 0 is the first enabled edge sampling run=1 in IDLE.
- eoc_rsa and cipher become valid together after 2 + WIDTH·(WIDTH + k) enabled edges.
  - k = popcount(exponent) in the default build.
  - k = WIDTH with RSA_CONST_TIME_EN.
- When modulus ≤ 1, latency is 2 edges and cipher=0.
- ena=0 cycles stretch the latency without changing the result.
- The controller sequence "en high with clear low, then clear high" is accepted: IDLE is held until clear_rsa rises.

## Configuration
- Macro: RSA_CONST_TIME_EN.
- **Defined:**
  - MULT executes for every exponent bit.
  - acc is updated with the product only when exponent[i]=1; otherwise the product is discarded.
  - Latency is data-independent: 2 + 2·WIDTH².
- **Undefined:** MULT is skipped for zero bits, as described in Operation.

## Structure
- Package rsa_pkg holds:
  - The state enum typedef.
  - RSA_WIDTH_DEFAULT = 8.
- Sub-module rsa_modmul contains:
  - The WIDTH-cycle interleaved modular multiplier.
  - A start/busy/done interface and the P register.
- rsa_modexp_core itself owns:
  - The exponent-scanning FSM.
  - The bit index and acc.
  - eoc_rsa and cipher.

## Test plan
All scenarios use WIDTH=8.
- **Encrypt:** modulus=221, exponent=5, plain=65, with en_rsa high and clear_rsa released one cycle later → cipher=182 and eoc_rsa=1 after 82 edges (130 with RSA_CONST_TIME_EN).
- **Decrypt:** modulus=221, exponent=77, plain=182 → cipher=65 after 98 edges (130 const-time). eoc_rsa stays high until en_rsa falls, then is 0 on the next edge.
- **Zero exponent:** exponent=0, modulus=221, plain=100 → cipher=1 after 66 edges (130 const-time).
- **Abort:** clear_rsa dropped mid-SQUARE → eoc_rsa=0, cipher keeps its previous value (182). A fresh run then completes correctly.
- **Degenerate modulus:** modulus=1 and modulus=0 → cipher=0 and eoc_rsa=1 after 2 edges.
- **Stalls and reset:**
  - ena toggling every other cycle during the encrypt scenario → cipher=182 after 82 enabled edges.
  - rstb low mid-run → eoc_rsa=0 and cipher=0 on the next edge.
